// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM with ALU decoder.
// Sequences each instruction and drives datapath muxes, write enables and the ALU function select.
module mc_controller #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    state_t state, next_state;
    logic   pcwrite, branch;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:   next_state = DECODE;
            DECODE: begin
                if (op == OP_LW || op == OP_SW) next_state = MEMADR;
                else if (op == OP_RTYPE)        next_state = RTYPEEX;
                else if (op == OP_BEQ)          next_state = BEQEX;
                else if (op == OP_ADDI)         next_state = ADDIEX;
                else if (op == OP_J)            next_state = JEX;
                else                            next_state = FETCH;
            end
            MEMADR:  next_state = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   next_state = MEMWB;
            RTYPEEX: next_state = RTYPEWB;
            ADDIEX:  next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b010;
        if (reset) begin
            // FETCH datapath selection with every write suppressed
            alusrcb = 2'b01;
        end else begin
            case (state)
                FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                end
                DECODE:  alusrcb = 2'b11;
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD:   iord = 1'b1;
                MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    case (funct)
                        6'b100000: alucontrol = 3'b010;
                        6'b100010: alucontrol = 3'b110;
                        6'b100100: alucontrol = 3'b000;
                        6'b100101: alucontrol = 3'b001;
                        6'b101010: alucontrol = 3'b111;
                        default:   alucontrol = 3'b011;
                    endcase
                end
                RTYPEWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                BEQEX: begin
                    alusrca    = 1'b1;
                    alucontrol = 3'b110;
                    pcsrc      = 2'b01;
                    branch     = 1'b1;
                end
                ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                ADDIWB:  regwrite = 1'b1;
                JEX: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
                default: ;
            endcase
        end
        pcen = pcwrite | (branch & zero);
    end
endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed and random instruction streams
// compared cycle by cycle against a per-instruction control-sequence model.
module tb_mc_controller;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    typedef struct packed {
        logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alucontrol;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset, zero;
    logic [5:0] op, funct;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    int         n_cmp = 0;
    int         n_err = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic ctl_t observed();
        ctl_t c;
        c = '{pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
              alusrcb, pcsrc, alucontrol};
        return c;
    endfunction

    function automatic int instr_len(input logic [5:0] o);
        case (o)
            LW:                return 5;
            SW, RT, ADDI:      return 4;
            BEQ, JMP:          return 3;
            default:           return 2;
        endcase
    endfunction

    function automatic logic [2:0] rtype_f(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b011;
        endcase
    endfunction

    // Expected control word for cycle k of an instruction (k=0 is its fetch cycle).
    function automatic ctl_t model(input logic [5:0] o, input logic [5:0] f, input logic z,
                                   input int k, input logic rst);
        ctl_t c;
        c = '0;
        c.alucontrol = 3'b010;
        if (rst) begin
            c.alusrcb = 2'b01;
            return c;
        end
        if (k == 0) begin
            c.pcen = 1'b1; c.irwrite = 1'b1; c.alusrcb = 2'b01;
        end else if (k == 1) begin
            c.alusrcb = 2'b11;
        end else begin
            case (o)
                LW, SW: begin
                    if (k == 2) begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
                    else if (o == LW && k == 3) c.iord = 1'b1;
                    else if (o == LW && k == 4) begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
                    else if (o == SW && k == 3) begin c.iord = 1'b1; c.memwrite = 1'b1; end
                end
                RT: begin
                    if (k == 2) begin c.alusrca = 1'b1; c.alucontrol = rtype_f(f); end
                    else begin c.regdst = 1'b1; c.regwrite = 1'b1; end
                end
                BEQ: begin
                    c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = z;
                end
                ADDI: begin
                    if (k == 2) begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
                    else c.regwrite = 1'b1;
                end
                JMP: begin
                    c.pcsrc = 2'b10; c.pcen = 1'b1;
                end
                default: ;
            endcase
        end
        return c;
    endfunction

    // Runs one instruction; rst_at selects a cycle in which reset is pulsed (-1: none).
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic bz,
                             input int rst_at);
        int len;
        len = instr_len(o);
        op = o;
        funct = f;
        for (int k = 0; k < len; k++) begin
            zero  = (o == BEQ && k == 2) ? bz : 1'($urandom);
            reset = (k == rst_at);
            @(negedge clk);
            check($sformatf("op=%b funct=%b cyc=%0d rst=%b", o, f, k, reset),
                  observed(), model(o, f, zero, k, reset));
            @(posedge clk);
            #1;
            if (reset) begin
                reset = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        logic [5:0] ro, rf;
        int         rst_at;
        reset = 1'b1;
        op    = 6'($urandom);
        funct = 6'($urandom);
        zero  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("reset", observed(), model(op, funct, zero, 0, 1'b1));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(LW,   6'b000000, 1'b0, -1);
        run_instr(RT,   6'b101010, 1'b0, -1);
        run_instr(RT,   6'b111111, 1'b0, -1);
        run_instr(BEQ,  6'b000000, 1'b1, -1);
        run_instr(BEQ,  6'b000000, 1'b0, -1);
        run_instr(JMP,  6'b000000, 1'b0, -1);
        run_instr(6'b111111, 6'b000000, 1'b1, -1);
        run_instr(SW,   6'b000000, 1'b0, -1);
        run_instr(ADDI, 6'b000000, 1'b0, -1);
        run_instr(RT,   6'b100000, 1'b0, -1);
        run_instr(RT,   6'b100010, 1'b0, -1);
        run_instr(RT,   6'b100100, 1'b0, -1);
        run_instr(RT,   6'b100101, 1'b0, -1);
        run_instr(SW,   6'b000000, 1'b0, 2);
        run_instr(LW,   6'b000000, 1'b0, 4);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 6))
                0:       ro = LW;
                1:       ro = SW;
                2:       ro = RT;
                3:       ro = BEQ;
                4:       ro = ADDI;
                5:       ro = JMP;
                default: ro = 6'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       rf = 6'b100000;
                1:       rf = 6'b100010;
                2:       rf = 6'b100100;
                3:       rf = 6'b100101;
                4:       rf = 6'b101010;
                default: rf = 6'($urandom);
            endcase
            rst_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(ro, rf, 1'($urandom), rst_at);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
